// File: rtl/m65c02a_int_hndlr.sv
// Interrupt handler for the M65C02A core.
// Synchronizes the external NMI/IRQ lines, latches NMI falling edges and the
// reset sequence as pending sources, raises a registered interrupt request to
// the core and supplies the vector of the highest-priority source
// (RST > NMI > IRQ). Once the core accepts an interrupt (le_int_i) the source
// and vector are frozen until the vector pull (vp_i) completes.
//
// Ports:
//   clk_i       system clock, rising edge
//   rst_ni      asynchronous active-low reset
//   nmi_ni      external NMI, asynchronous, falling-edge sensitive
//   irq_ni      external IRQ, asynchronous, active-low level
//   irq_msk_i   core I flag, 1 masks IRQ
//   le_int_i    core has accepted the pending interrupt
//   vp_i        core vector-pull indicator
//   int_o       interrupt request to core
//   xirq_o      synchronized, unmasked IRQ level (1 = asserted)
//   vector_o    ISR vector address
//   nmi_pend_o  NMI latched, not yet serviced
//   rst_pend_o  reset sequence not yet serviced
module m65c02a_int_hndlr #(
  parameter logic [15:0] pRST_Vec = 16'hFFFC,
  parameter logic [15:0] pNMI_Vec = 16'hFFFA,
  parameter logic [15:0] pIRQ_Vec = 16'hFFFE
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        nmi_ni,
  input  logic        irq_ni,
  input  logic        irq_msk_i,
  input  logic        le_int_i,
  input  logic        vp_i,
  output logic        int_o,
  output logic        xirq_o,
  output logic [15:0] vector_o,
  output logic        nmi_pend_o,
  output logic        rst_pend_o
);

  typedef enum logic [1:0] {StIdle, StHold, StAck} state_e;
  typedef enum logic [1:0] {SrcRst, SrcNmi, SrcIrq} src_e;

  state_e state_q, state_d;
  src_e   src_q, src_d, sel_src, vec_src;

  logic nmi_s1_q, nmi_s2_q, nmi_dly_q;
  logic irq_s1_q, irq_s2_q;
  logic nmi_pend_q, rst_pend_q, int_q;
  logic nmi_fall, clr_nmi, clr_rst;

  // Synchronizers and NMI edge register; idle level of the lines is high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      nmi_s1_q  <= 1'b1;
      nmi_s2_q  <= 1'b1;
      nmi_dly_q <= 1'b1;
      irq_s1_q  <= 1'b1;
      irq_s2_q  <= 1'b1;
    end else begin
      nmi_s1_q  <= nmi_ni;
      nmi_s2_q  <= nmi_s1_q;
      nmi_dly_q <= nmi_s2_q;
      irq_s1_q  <= irq_ni;
      irq_s2_q  <= irq_s1_q;
    end
  end

  assign nmi_fall = nmi_dly_q & ~nmi_s2_q;
  assign xirq_o   = ~irq_s2_q;

  // With nothing pending IRQ is selected so the vector defaults to pIRQ_Vec.
  always_comb begin
    if (rst_pend_q)      sel_src = SrcRst;
    else if (nmi_pend_q) sel_src = SrcNmi;
    else                 sel_src = SrcIrq;
  end

  // Pending flags and registered request; a new NMI edge beats the clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      nmi_pend_q <= 1'b0;
      rst_pend_q <= 1'b1;
      int_q      <= 1'b0;
    end else begin
      nmi_pend_q <= nmi_fall | (nmi_pend_q & ~clr_nmi);
      rst_pend_q <= rst_pend_q & ~clr_rst;
      int_q      <= rst_pend_q | nmi_pend_q | (xirq_o & ~irq_msk_i);
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      src_q   <= SrcRst;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    unique case (state_q)
      StIdle: begin
        if (le_int_i && int_q) begin
          state_d = StHold;
          src_d   = sel_src;
        end
      end
      StHold:  if (vp_i)  state_d = StAck;
      StAck:   if (!vp_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: source clear on HOLD->ACK, vector tracks live priority only
  // while idle.
  always_comb begin
    clr_rst = 1'b0;
    clr_nmi = 1'b0;
    if (state_q == StHold && vp_i) begin
      clr_rst = (src_q == SrcRst);
      clr_nmi = (src_q == SrcNmi);
    end
    vec_src = (state_q == StIdle) ? sel_src : src_q;
    case (vec_src)
      SrcRst:  vector_o = pRST_Vec;
      SrcNmi:  vector_o = pNMI_Vec;
      default: vector_o = pIRQ_Vec;
    endcase
  end

  assign int_o      = int_q;
  assign nmi_pend_o = nmi_pend_q;
  assign rst_pend_o = rst_pend_q;

endmodule

// File: doc/m65c02a_int_hndlr.md
M65C02A_INT_HNDLR -- requirements
Module: m65c02a_int_hndlr

Interface
REQ-001 Parameter pRST_Vec, default 16'hFFFC, reset vector address.
REQ-002 Parameter pNMI_Vec, default 16'hFFFA, NMI vector address.
REQ-003 Parameter pIRQ_Vec, default 16'hFFFE, IRQ/BRK vector address.
REQ-004 Clk  input  1  single system clock; all state changes on rising edge.
REQ-005 Rst  input  1  reset, asynchronous, active-low.
REQ-006 nNMI  input  1  external non-maskable interrupt, asynchronous, falling-edge sensitive.
REQ-007 nIRQ  input  1  external maskable interrupt, asynchronous, active-low level.
REQ-008 IRQ_Msk  input  1  core I flag; 1 masks IRQ.
REQ-009 LE_Int  input  1  core strobe; 1 = core has accepted the pending interrupt, freeze vector.
REQ-010 VP  input  1  core vector-pull indicator; high while vector is read.
REQ-011 Int  output  1  interrupt request to core.
REQ-012 xIRQ  output  1  synchronized, unmasked IRQ level to core (1 = asserted).
REQ-013 Vector  output  16  ISR vector address to core.
REQ-014 NMI_Pend  output  1  NMI latched, not yet serviced.
REQ-015 RST_Pend  output  1  reset sequence not yet serviced.

Function
REQ-016 nNMI and nIRQ SHALL each pass a 2-flop synchronizer (reset value 1) before any use.
REQ-017 NMI edge detector SHALL register the synchronized nNMI; a 1->0 transition sets NMI_Pend; total latency from first-sampled low to NMI_Pend=1 is 3 Clk edges.
REQ-018 xIRQ SHALL equal inverted synchronized nIRQ (2-edge latency), unaffected by IRQ_Msk.
REQ-019 Int SHALL be registered: Int <= RST_Pend | NMI_Pend | (xIRQ & ~IRQ_Msk), 1-cycle latency from sources.
REQ-020 Priority SHALL be RST > NMI > IRQ.
REQ-021 FSM states: IDLE, HOLD, ACK.
REQ-022 IDLE: Vector SHALL update each cycle to highest-priority pending source's vector (pIRQ_Vec when none pending); LE_Int=1 with Int=1 -> HOLD, capturing source ID (RST/NMI/IRQ).
REQ-023 HOLD: Vector and captured source SHALL stay frozen regardless of new requests or IRQ withdrawal; VP=1 -> ACK.
REQ-024 On HOLD->ACK transition the captured source's pending flag SHALL clear (RST_Pend or NMI_Pend; IRQ has no latch).
REQ-025 ACK: Vector stays frozen; VP=0 -> IDLE.
REQ-026 LE_Int in HOLD or ACK SHALL be ignored.
REQ-027 NMI edge detected in same cycle as NMI clear SHALL leave NMI_Pend=1 (set wins).
REQ-028 NMI edges while NMI_Pend=1 SHALL not queue; a single pending NMI is held.
REQ-029 nNMI held low SHALL produce exactly one NMI; a new NMI requires return high then low.
REQ-030 LE_Int with Int=0 in IDLE SHALL remain in IDLE.

Reset
REQ-031 Rst=0 SHALL asynchronously force: synchronizer flops 1, edge register 1, NMI_Pend 0, RST_Pend 1, Int 0, xIRQ 0, Vector pRST_Vec, FSM IDLE.
REQ-032 Rst assertion in any state SHALL abort the in-progress sequence; no pending NMI survives reset.
REQ-033 After Rst release, Int SHALL go 1 on first Clk edge and remain until RST vector is pulled per REQ-022..025.
REQ-034 Rst deassertion SHALL be the only reset input; no synchronous clear exists.

Verification
REQ-035 Release Rst; pulse LE_Int 1 cycle, VP 2 cycles -> Vector=16'hFFFC throughout, RST_Pend 1->0 on VP entry, Int=0 one cycle later.
REQ-036 After reset serviced, drive nNMI 1->0 held 10 cycles -> NMI_Pend=1 on 3rd edge, Int=1 on 4th, Vector=16'hFFFA; after LE_Int/VP handshake exactly one NMI serviced, NMI_Pend=0.
REQ-037 nIRQ=0, IRQ_Msk=1 -> xIRQ=1, Int=0, Vector=16'hFFFE; drop IRQ_Msk -> Int=1 next cycle.
REQ-038 nIRQ=0 and IRQ_Msk=0, LE_Int -> HOLD with Vector=16'hFFFE; then nNMI falls -> Vector stays 16'hFFFE until VP falls; in IDLE Vector becomes 16'hFFFA and Int remains 1.
REQ-039 Second nNMI falling edge timed to coincide with NMI clear (HOLD->ACK) -> NMI_Pend remains 1, second NMI serviced.
REQ-040 Assert Rst mid-HOLD with NMI_Pend=1 -> immediately NMI_Pend=0, RST_Pend=1, Vector=16'hFFFC, FSM IDLE.
